muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  input  32  rs1 operand (multiplicand/dividend), taken from the register-file read port.
REQ-007 b  input  32  rs2 operand (multiplier/divisor), taken from the register-file read port.
REQ-008 rd_in  input  5  destination register tag, carried with the operation.
REQ-009 kill  input  1  abort any in-flight operation (pipeline flush).
REQ-010 busy  output  1  operation in flight; new start is not accepted.
REQ-011 result_valid  output  1  one-cycle pulse; drives the register-file write enable.
REQ-012 result  output  32  operation result; drives register-file rd_data.
REQ-013 rd_out  output  5  captured rd_in tag; drives register-file rd.

Function
REQ-014 The unit SHALL implement three states: IDLE, CALC, DONE.
REQ-015 In IDLE with start=1 and kill=0, the edge SHALL capture a, b, funct3 and rd_in, set busy=1, and enter CALC with a 5-bit iteration counter at 0.
REQ-016 Capture SHALL convert signed operands to magnitude and record the result sign:
- MULH: both operands signed.
- MULHSU: a signed, b unsigned.
- DIV/REM: both operands signed.
REQ-017 CALC SHALL execute exactly one iteration per cycle for 32 cycles:
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract producing 32-bit quotient and remainder.
REQ-018 When the counter wraps from 31 to 0, the unit SHALL apply sign fixup, load result, and enter DONE.
REQ-019 In DONE, result_valid SHALL be 1 for exactly one cycle, busy SHALL be 0, and the next state SHALL be IDLE.
REQ-020 result_valid SHALL assert in the cycle after the 33rd rising edge following the accepting edge; latency SHALL be identical for all ops and operand values.
REQ-021 Result selection:
- MUL: low 32 bits of the product.
- MULH/MULHSU/MULHU: high 32 bits of the product.
- DIV/DIVU: quotient.
- REM/REMU: remainder.
- Remainder sign SHALL equal the dividend sign.
REQ-022 Divide by zero (b=0), all four divide ops:
- Quotient SHALL be 0xFFFFFFFF.
- Remainder SHALL equal a.
REQ-023 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF):
- Quotient SHALL be 0x80000000.
- Remainder SHALL be 0.
REQ-024 result and rd_out SHALL hold their values after DONE until the next operation completes.
REQ-025 start while busy=1 or while in DONE SHALL be ignored; captured operands SHALL not change.
REQ-026 kill=1 in any state SHALL force IDLE on the next edge with busy=0 and no result_valid pulse.
REQ-027 kill=1 coinciding with start in IDLE SHALL cause the start to be ignored.
REQ-028 kill=1 in DONE SHALL suppress result_valid in that same cycle; result_valid = DONE & ~kill.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE, busy=0, result_valid=0;
- result=0, rd_out=0;
- counter and internal accumulators to 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no result_valid pulse SHALL follow reset release.

Verification
REQ-031 MUL a=7, b=0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out=5, single result_valid pulse exactly 33 edges after the accepting edge.
REQ-032 MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH a=b=0x80000000 -> result 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> result 0xFFFFFFFF.
REQ-033 DIV a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-034 DIVU a=100, b=0 -> 0xFFFFFFFF; REMU a=100, b=0 -> 100; DIV a=0xFFFFFF9C, b=0 -> 0xFFFFFFFF.
REQ-035 Start DIVU 100/7, then a second start at cycle 5 with different operands -> second start ignored, result 14.
REQ-036 Start DIVU 100/7, kill at cycle 10 -> busy=0 next cycle, no result_valid pulse.
REQ-037 Start DIVU 100/7, reset_n=0 at cycle 20 -> all outputs 0 immediately, no result_valid after release.
REQ-038 After REQ-036 or REQ-037, a new MUL 3*4 -> result 12 with normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One iteration per cycle; fixed 33-edge latency from accept to result for every op.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start, funct3      request and op select (MUL..REMU)
//   a, b               rs1 / rs2 operands
//   rd_in              destination tag carried with the operation
//   kill               abort any in-flight operation
//   busy               operation in flight (CALC)
//   result_valid       one-cycle write-enable pulse
//   result, rd_out     result and tag, held until the next completion
module muldiv_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd_in,
  input  logic        kill,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q;
  logic [4:0]  cnt_q;
  logic        prep_q;
  logic [2:0]  op_q;
  logic [31:0] opa_q, opb_q;
  logic [63:0] acc_q;
  logic        neg_q, rneg_q, div0_q;
  logic [4:0]  rd_cap_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  // Operand sign handling at capture
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed & a[31];
    b_neg    = b_signed & b[31];
    a_mag    = a_neg ? (~a + 32'd1) : a;
    b_mag    = b_neg ? (~b + 32'd1) : b;
  end

  // One iteration. Multiply: acc = {high, multiplier}; divide: acc = {remainder, quotient}.
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (op_q[2]) begin
      // Borrow means the trial subtract failed: restore and shift in 0
      acc_next = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                              : {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc_q[31:1]};
    end
  end

  // Sign fixup and result selection from the final iteration
  logic [63:0] prod;
  logic [31:0] quo_fix, rem_fix, res_fix;

  always_comb begin
    prod    = neg_q ? (~acc_next + 64'd1) : acc_next;
    quo_fix = div0_q ? 32'hFFFF_FFFF
                     : (neg_q ? (~acc_next[31:0] + 32'd1) : acc_next[31:0]);
    rem_fix = rneg_q ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
    unique case (op_q)
      3'b000:                 res_fix = prod[31:0];
      3'b001, 3'b010, 3'b011: res_fix = prod[63:32];
      3'b100, 3'b101:         res_fix = quo_fix;
      default:                res_fix = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      prep_q   <= 1'b0;
      op_q     <= 3'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      rd_cap_q <= 5'd0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else if (kill) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      prep_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= funct3;
            opa_q    <= a_mag;
            opb_q    <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            div0_q   <= (b == 32'd0);
            rd_cap_q <= rd_in;
            cnt_q    <= 5'd0;
            prep_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (prep_q) begin
            // First CALC cycle loads the accumulator; the same init serves mul and div
            acc_q  <= {32'd0, opa_q};
            prep_q <= 1'b0;
          end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              result_q <= res_fix;
              rd_out_q <= rd_cap_q;
              state_q  <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q == CALC);
  assign result_valid = (state_q == DONE) & ~kill;
  assign result       = result_q;
  assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        kill = 1'b0;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  muldiv_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .funct3       (funct3),
    .a            (a),
    .b            (b),
    .rd_in        (rd_in),
    .kill         (kill),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .rd_out       (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] rd);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    a      = av;
    b      = bv;
    rd_in  = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait up to 40 edges for result_valid; it must appear after exactly 'want' edges.
  task automatic wait_result(input string tag, input int want);
    int          n;
    bit          seen;
    logic [36:0] e;
    n    = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (result_valid) seen = 1'b1;
    end
    check({tag, " latency"}, 64'(n), 64'(want));
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, " result"}, 64'(result), 64'(e[36:5]));
      check({tag, " rd_out"}, 64'(rd_out), 64'(e[4:0]));
    end
    @(posedge clk);
    #1;
    check({tag, " single pulse"}, 64'(result_valid), 64'(0));
    check({tag, " result hold"}, 64'(result), 64'(e[36:5]));
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] rd, input logic [31:0] exp);
    exp_q.push_back({exp, rd});
    issue(f, av, bv, rd);
    check({tag, " busy"}, 64'(busy), 64'(1));
    wait_result(tag, 33);
  endtask

  task automatic expect_no_pulse(input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) pulses++;
    end
    check(tag, 64'(pulses), 64'(0));
  endtask

  initial begin
    // Reset values, before any clock edge
    #3;
    check("reset busy", 64'(busy), 64'(0));
    check("reset valid", 64'(result_valid), 64'(0));
    check("reset result", 64'(result), 64'(0));
    check("reset rd_out", 64'(rd_out), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mul neg", F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    run_op("mulhu max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
    run_op("mulh min", F_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
    run_op("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF);
    run_op("div neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    run_op("rem neg", F_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    run_op("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000);
    run_op("rem ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000);
    run_op("divu by0", F_DIVU, 32'd100, 32'd0, 5'd9, 32'hFFFF_FFFF);
    run_op("remu by0", F_REMU, 32'd100, 32'd0, 5'd10, 32'd100);
    run_op("div by0", F_DIV, 32'hFFFF_FF9C, 32'd0, 5'd11, 32'hFFFF_FFFF);
    run_op("rem by0", F_REM, 32'hFFFF_FF9C, 32'd0, 5'd12, 32'hFFFF_FF9C);

    // Second start while busy is ignored
    exp_q.push_back({32'd14, 5'd3});
    issue(F_DIVU, 32'd100, 32'd7, 5'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    issue(F_MUL, 32'd9, 32'd9, 5'd9);
    check("restart busy", 64'(busy), 64'(1));
    wait_result("restart", 28);

    // Kill mid-operation
    issue(F_DIVU, 32'd100, 32'd7, 5'd13);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill busy", 64'(busy), 64'(0));
    expect_no_pulse("kill no pulse");
    check("kill result hold", 64'(result), 64'(14));
    check("kill rd hold", 64'(rd_out), 64'(3));
    run_op("mul after kill", F_MUL, 32'd3, 32'd4, 5'd7, 32'd12);

    // Asynchronous reset mid-operation
    issue(F_DIVU, 32'd100, 32'd7, 5'd14);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'(0));
    check("async rst valid", 64'(result_valid), 64'(0));
    check("async rst result", 64'(result), 64'(0));
    check("async rst rd_out", 64'(rd_out), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expect_no_pulse("reset no pulse");
    run_op("mul after reset", F_MUL, 32'd3, 32'd4, 5'd7, 32'd12);

    check("scoreboard empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
